// File: rtl/data_mem_alt_pkg.sv
// Shared defaults for the frame-buffer data store.
// The frame buffer's common constants may mirror these values.
package data_mem_alt_pkg;
    localparam int DMA_DATA_WIDTH = 32;
    localparam int DMA_ADDR_WIDTH = 8;
endpackage

// File: rtl/data_mem_alt_ram_core.sv
// Plain storage array with a synchronous write port and a combinational read.
// The read register and the write-first bypass live in the wrapper.
module data_mem_alt_ram_core #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the word on every enabled write; no reset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // Unregistered read of the addressed word.
    always_comb begin
        rdata = mem[raddr];
    end
endmodule

// File: rtl/data_mem_alt.sv
// Simple dual-port RAM: one write port, one read port, registered read data.
// A same-address read and write returns the incoming write data (write-first).
module data_mem_alt
    import data_mem_alt_pkg::*;
#(
    parameter int DATA_WIDTH = DMA_DATA_WIDTH,
    parameter int ADDR_WIDTH = DMA_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  bypass_hit;
    logic [DATA_WIDTH-1:0] rd_next;

    // Writes are dropped while reset is asserted; memory contents are kept.
    assign ram_we = wr_en & ~reset;

    data_mem_alt_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram_core (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Same-address compare selects the incoming word so the read never sees stale data.
    always_comb begin
        bypass_hit = wr_en && (wr_addr == rd_addr);
        rd_next    = bypass_hit ? wr_data : ram_rdata;
    end

    // Output register: cleared on reset, loaded on read, held when idle.
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= rd_next;
    end
endmodule

// File: tb/tb_data_mem_alt.sv
// Bench for data_mem_alt: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a behavioural model.
module tb_data_mem_alt;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_alt #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .wr_addr (wr_addr),
        .rd_addr (rd_addr),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // Behavioural model: word array with "written" flags and the expected output word.
    logic [DW-1:0] mdl_mem [DEPTH];
    logic          mdl_wr  [DEPTH] = '{default: 1'b0};
    logic [DW-1:0] exp_rd = '0;
    logic          exp_known = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            exp_rd    <= '0;
            exp_known <= 1'b1;
        end else begin
            if (rd_en) begin
                if (wr_en && wr_addr == rd_addr) begin
                    exp_rd    <= wr_data;
                    exp_known <= 1'b1;
                end else begin
                    exp_rd    <= mdl_mem[rd_addr];
                    exp_known <= mdl_wr[rd_addr];
                end
            end
            if (wr_en) begin
                mdl_mem[wr_addr] <= wr_data;
                mdl_wr[wr_addr]  <= 1'b1;
            end
        end
    end

    // Every-cycle compare against the model, on the falling edge.
    always @(negedge clk) begin
        if (exp_known) begin
            n_cmp++;
            if (rd_data !== exp_rd) begin
                n_bad++;
                $display("FAIL model_cmp t=%0t rd_data=%h expected=%h", $time, rd_data, exp_rd);
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] exp);
        n_cmp++;
        if (rd_data !== exp) begin
            n_bad++;
            $display("FAIL %s rd_data=%h expected=%h", name, rd_data, exp);
        end
    endtask

    // Present one cycle of inputs, then return 1 time unit after the edge.
    task automatic cyc(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        // Reset with a read pending and a write that must be dropped.
        cyc(1, 1, 3'd1, 16'hDEAD, 1, 3'd1);
        cyc(1, 1, 3'd1, 16'hDEAD, 1, 3'd1);
        check("reset_clear", 16'h0000);

        // Sequential fill, read port idle.
        for (int i = 1; i <= 4; i++)
            cyc(0, 1, 3'(i), 16'(i), 0, 3'd0);
        check("idle_hold_after_reset", 16'h0000);

        // Write during reset to addr 1 must not land.
        cyc(1, 1, 3'd1, 16'hDEAD, 1, 3'd2);
        check("reset_mid", 16'h0000);

        // Read back 1..4.
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 3'd0, 16'h0, 1, 3'(i));
            check($sformatf("seq_read_%0d", i), 16'(i));
        end

        // Hold: read addr 2, then idle while rd_addr moves.
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd2);
        check("hold_load", 16'h0002);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 3'd0, 16'h0, 0, 3'(i + 4));
            check($sformatf("hold_%0d", i), 16'h0002);
        end

        // Write-first collision on addr 5.
        cyc(0, 1, 3'd5, 16'hAAAA, 0, 3'd0);
        cyc(0, 1, 3'd5, 16'h5555, 1, 3'd5);
        check("collision_bypass", 16'h5555);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd5);
        check("collision_stored", 16'h5555);

        // Independent ports in the same cycle.
        cyc(0, 1, 3'd7, 16'h0007, 1, 3'd3);
        check("concurrent_read", 16'h0003);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd7);
        check("concurrent_write", 16'h0007);

        // Boundary addresses, with neighbours verified unchanged.
        cyc(0, 1, 3'd6, 16'h0606, 0, 3'd0);
        cyc(0, 1, 3'd0, 16'hBEEF, 0, 3'd0);
        cyc(0, 1, 3'd7, 16'hCAFE, 0, 3'd0);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd0);
        check("bound_lo", 16'hBEEF);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd7);
        check("bound_hi", 16'hCAFE);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd1);
        check("adj_lo", 16'h0001);
        cyc(0, 0, 3'd0, 16'h0, 1, 3'd6);
        check("adj_hi", 16'h0606);

        // Randomized traffic with occasional resets; the model checks every cycle.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(39) == 0), 1'($urandom), 3'($urandom), 16'($urandom),
                1'($urandom), (($urandom_range(3) == 0) ? wr_addr : 3'($urandom)));
        end
        cyc(0, 0, 3'd0, 16'h0, 0, 3'd0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
